uart_receiver: RTL

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter, sharing its 16x oversampling baud tick (s_tick). It synchronises the asynchronous rx line, detects and qualifies the start bit, and samples each data bit at mid-bit, LSB first. It checks the stop bit and delivers each word through a one-entry holding register with a valid/read handshake, framing-error flag and overrun flag.

---
 rtl/uart_receiver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled start/data/stop framing into a one-word
// holding register with read handshake, framing-error and sticky overrun flags.
module uart_receiver #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_uart,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_meta;
  logic            rx_s;
  logic            frame_end;

  // Synchroniser resets to the idle line level so reset release never
  // looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              // A line that is high again at mid start bit was only a glitch.
              if (!rx_s) begin
                s     <= '0;
                n     <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_end = (state == STOP) && s_tick && (s == S_STOP);

  // A read arriving with a new word hands the consumer the old one, so the
  // incoming word is not counted as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_dout      <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= frame_end;
      if (frame_end) begin
        rx_dout   <= b;
        rx_valid  <= 1'b1;
        frame_err <= ~rx_s;
        if (rd_uart) begin
          overrun_err <= 1'b0;
        end else if (rx_valid) begin
          overrun_err <= 1'b1;
        end
      end else if (rd_uart && rx_valid) begin
        rx_valid    <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule
